// File: rtl/cdf_accumulate_pkg.sv
// rtl/cdf_accumulate_pkg.sv - shared constants, state encoding and lane helper for the CDF stage
package cdf_accumulate_pkg;

  localparam int NUM_BINS   = 256;
  localparam int LANES      = 4;
  localparam int NUM_WORDS  = NUM_BINS / LANES;
  localparam int LANE_W     = 32;
  localparam int WORD_W     = LANES * LANE_W;
  localparam int IDX_W      = $clog2(NUM_WORDS);
  localparam int LANE_IDX_W = $clog2(LANES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } cdf_state_e;

  // Lane k of a scratch word occupies bits [32k+31:32k].
  function automatic logic [LANE_W-1:0] lane_slice(input logic [WORD_W-1:0] word,
                                                   input int lane);
    return LANE_W'(word >> (lane * LANE_W));
  endfunction

endpackage

// File: rtl/cdf_prefix4.sv
// rtl/cdf_prefix4.sv - combinational 4-lane prefix sum on top of a running accumulator
module cdf_prefix4
  import cdf_accumulate_pkg::*;
(
  input  logic [LANE_W-1:0]            acc,
  input  logic [WORD_W-1:0]            word,
  output logic [LANES-1:0][LANE_W-1:0] lane_cdf,
  output logic [LANE_IDX_W-1:0]        first_idx,
  output logic                         first_vld
);

  logic [LANE_W-1:0] run_sum;

  // Lowest lane with a non-zero running sum wins the first-non-zero report.
  always_comb begin
    run_sum   = acc;
    lane_cdf  = '0;
    first_idx = '0;
    first_vld = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      run_sum     = run_sum + lane_slice(word, k);
      lane_cdf[k] = run_sum;
      if (!first_vld && (run_sum != '0)) begin
        first_vld = 1'b1;
        first_idx = LANE_IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/cdf_accumulate.sv
// rtl/cdf_accumulate.sv - reads the 256-bin histogram, writes its running CDF and reports cdf_min
module cdf_accumulate
  import cdf_accumulate_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] HIST_BASE = 16'h0000,
  parameter logic [ADDR_W-1:0] CDF_BASE  = 16'h0040
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [WORD_W-1:0] sc_mem_rd_data1,
  output logic [ADDR_W-1:0] sc_mem_rd_addr1,
  output logic [WORD_W-1:0] sc_mem_wt_data,
  output logic [ADDR_W-1:0] sc_mem_wt_addr,
  output logic              sc_mem_wt_en,
  output logic [LANE_W-1:0] cdf_min,
  output logic              cdf_busy,
  output logic              cdf_done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  cdf_state_e state_q, state_d;

  logic              start;
  logic              issue;

  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_pend_q, rd_pend_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic [WORD_W-1:0] wt_data_q, wt_data_d;
  logic [ADDR_W-1:0] wt_addr_q, wt_addr_d;
  logic              wt_en_q, wt_en_d;
  logic [LANE_W-1:0] acc_q, acc_d;
  logic [LANE_W-1:0] cdf_min_q, cdf_min_d;
  logic              min_found_q, min_found_d;

  logic [LANES-1:0][LANE_W-1:0] lane_cdf;
  logic [LANE_IDX_W-1:0]        first_idx;
  logic                         first_vld;

  cdf_prefix4 u_prefix (
    .acc       (acc_q),
    .word      (sc_mem_rd_data1),
    .lane_cdf  (lane_cdf),
    .first_idx (first_idx),
    .first_vld (first_vld)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FLUSH exits once the last returned word has been consumed by the write stage.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (cnt_q == LAST_IDX) state_d = FLUSH;
      FLUSH:   if (!rd_pend_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start    = 1'b0;
    issue    = 1'b0;
    cdf_busy = 1'b0;
    cdf_done = 1'b0;
    case (state_q)
      IDLE:    start = enable;
      RUN: begin
        issue    = 1'b1;
        cdf_busy = 1'b1;
      end
      FLUSH:   cdf_busy = 1'b1;
      DONE:    cdf_done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    rd_addr_d   = rd_addr_q;
    rd_pend_d   = issue;
    rd_idx_d    = cnt_q;
    wt_data_d   = wt_data_q;
    wt_addr_d   = wt_addr_q;
    wt_en_d     = rd_pend_q;
    acc_d       = acc_q;
    cdf_min_d   = cdf_min_q;
    min_found_d = min_found_q;

    if (start) begin
      cnt_d       = '0;
      rd_addr_d   = HIST_BASE;
      acc_d       = '0;
      cdf_min_d   = '0;
      min_found_d = 1'b0;
    end

    // The read address parks on the last histogram word rather than running past it.
    if (issue && (cnt_q != LAST_IDX)) begin
      cnt_d     = cnt_q + IDX_W'(1);
      rd_addr_d = HIST_BASE + ADDR_W'(cnt_q + IDX_W'(1));
    end

    if (rd_pend_q) begin
      wt_data_d = lane_cdf;
      wt_addr_d = CDF_BASE + ADDR_W'(rd_idx_q);
      acc_d     = lane_cdf[LANES-1];
      if (!min_found_q && first_vld) begin
        cdf_min_d   = lane_cdf[first_idx];
        min_found_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q       <= '0;
      rd_addr_q   <= '0;
      rd_pend_q   <= 1'b0;
      rd_idx_q    <= '0;
      wt_data_q   <= '0;
      wt_addr_q   <= '0;
      wt_en_q     <= 1'b0;
      acc_q       <= '0;
      cdf_min_q   <= '0;
      min_found_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rd_addr_q   <= rd_addr_d;
      rd_pend_q   <= rd_pend_d;
      rd_idx_q    <= rd_idx_d;
      wt_data_q   <= wt_data_d;
      wt_addr_q   <= wt_addr_d;
      wt_en_q     <= wt_en_d;
      acc_q       <= acc_d;
      cdf_min_q   <= cdf_min_d;
      min_found_q <= min_found_d;
    end
  end

  assign sc_mem_rd_addr1 = rd_addr_q;
  assign sc_mem_wt_data  = wt_data_q;
  assign sc_mem_wt_addr  = wt_addr_q;
  assign sc_mem_wt_en    = wt_en_q;
  assign cdf_min         = cdf_min_q;

endmodule

// File: tb/tb_cdf_accumulate.sv
// tb/tb_cdf_accumulate.sv - directed table-driven bench for cdf_accumulate
module tb_cdf_accumulate;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [127:0] rd_data;
  logic [15:0]  rd_addr;
  logic [127:0] wt_data;
  logic [15:0]  wt_addr;
  logic         wt_en;
  logic [31:0]  cdf_min;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;
  int oob   = 0;

  logic [127:0] hist    [64];
  logic [127:0] cdf_out [64];

  typedef struct {
    int           pat;
    int           word;
    logic [127:0] exp;
  } vec_t;

  vec_t        vecs    [14];
  logic [31:0] min_exp [5];

  int first_wt, last_wt, nwr, done_at, ndone, nbusy, addr_err;

  always #5 clk = ~clk;

  cdf_accumulate dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .sc_mem_rd_data1 (rd_data),
    .sc_mem_rd_addr1 (rd_addr),
    .sc_mem_wt_data  (wt_data),
    .sc_mem_wt_addr  (wt_addr),
    .sc_mem_wt_en    (wt_en),
    .cdf_min         (cdf_min),
    .cdf_busy        (busy),
    .cdf_done        (done)
  );

  always @(posedge clk) begin
    rd_data <= hist[rd_addr[5:0]];
    if (rd_addr > 16'd63) oob <= oob + 1;
  end

  function automatic logic [127:0] w4(input logic [31:0] l3, input logic [31:0] l2,
                                      input logic [31:0] l1, input logic [31:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic load_pattern(input int p);
    logic [31:0] v;
    for (int b = 0; b < 256; b++) begin
      case (p)
        0:       v = 32'd1;
        1:       v = (b < 17) ? 32'd0 : ((b == 17) ? 32'd18 : 32'd1);
        2:       v = (b == 255) ? 32'd65536 : 32'd0;
        4:       v = (b == 6) ? 32'd5 : ((b == 7) ? 32'd9 : 32'd0);
        default: v = 32'd0;
      endcase
      hist[b / 4][(b % 4) * 32 +: 32] = v;
    end
  endtask

  task automatic start_pulse();
    @(negedge clk);
    enable = 1'b1;
    @(posedge clk);
    #1 enable = 1'b0;
  endtask

  // Cycle k of the loop is cycle t0+k, where t0 is the edge that accepted enable.
  task automatic run_pass(input int repulse_at);
    first_wt = -1; last_wt = -1; nwr = 0; done_at = -1; ndone = 0; nbusy = 0; addr_err = 0;
    for (int w = 0; w < 64; w++) cdf_out[w] = 'x;
    start_pulse();
    for (int k = 1; k <= 72; k++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (wt_en) begin
        if (first_wt < 0) first_wt = k;
        last_wt = k;
        nwr++;
        if (wt_addr !== 16'(32'h40 + k - 3)) addr_err++;
        if (wt_addr >= 16'h40 && wt_addr < 16'h80) cdf_out[wt_addr[5:0]] = wt_data;
      end
      if (done) begin
        ndone++;
        done_at = k;
      end
      enable = (k == repulse_at);
    end
    enable = 1'b0;
  endtask

  task automatic check_pass(input int p);
    check($sformatf("p%0d_first_wt", p), 256'(first_wt), 256'(3));
    check($sformatf("p%0d_last_wt", p), 256'(last_wt), 256'(66));
    check($sformatf("p%0d_writes", p), 256'(nwr), 256'(64));
    check($sformatf("p%0d_wt_addr_seq", p), 256'(addr_err), 256'(0));
    check($sformatf("p%0d_done_at", p), 256'(done_at), 256'(67));
    check($sformatf("p%0d_done_count", p), 256'(ndone), 256'(1));
    check($sformatf("p%0d_busy_cycles", p), 256'(nbusy), 256'(66));
    check($sformatf("p%0d_cdf_min", p), 256'(cdf_min), 256'(min_exp[p]));
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].pat == p)
        check($sformatf("p%0d_word%0d", p, vecs[i].word),
              256'(cdf_out[vecs[i].word]), 256'(vecs[i].exp));
    end
  endtask

  initial begin
    vecs[0]  = '{0, 0,  w4(4, 3, 2, 1)};
    vecs[1]  = '{0, 10, w4(44, 43, 42, 41)};
    vecs[2]  = '{0, 63, w4(256, 255, 254, 253)};
    vecs[3]  = '{1, 3,  w4(0, 0, 0, 0)};
    vecs[4]  = '{1, 4,  w4(20, 19, 18, 0)};
    vecs[5]  = '{1, 5,  w4(24, 23, 22, 21)};
    vecs[6]  = '{1, 63, w4(256, 255, 254, 253)};
    vecs[7]  = '{2, 0,  w4(0, 0, 0, 0)};
    vecs[8]  = '{2, 62, w4(0, 0, 0, 0)};
    vecs[9]  = '{2, 63, w4(65536, 0, 0, 0)};
    vecs[10] = '{3, 0,  w4(0, 0, 0, 0)};
    vecs[11] = '{3, 63, w4(0, 0, 0, 0)};
    vecs[12] = '{4, 1,  w4(14, 5, 0, 0)};
    vecs[13] = '{4, 63, w4(14, 14, 14, 14)};
    min_exp[0] = 32'd1;
    min_exp[1] = 32'h12;
    min_exp[2] = 32'h10000;
    min_exp[3] = 32'd0;
    min_exp[4] = 32'd5;

    reset  = 1'b0;
    enable = 1'b0;
    load_pattern(3);
    repeat (3) @(negedge clk);
    check("reset_outputs", 256'({rd_addr, wt_addr, wt_data, wt_en, cdf_min, busy, done}), '0);
    reset = 1'b1;

    // Pattern 0 also re-pulses enable mid-run, which must be ignored.
    for (int p = 0; p < 5; p++) begin
      load_pattern(p);
      run_pass((p == 0) ? 20 : 0);
      check_pass(p);
    end

    load_pattern(0);
    start_pulse();
    repeat (30) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_outputs", 256'({rd_addr, wt_addr, wt_data, wt_en, cdf_min, busy, done}), '0);
    reset = 1'b1;
    nwr = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (wt_en || busy) nwr++;
    end
    check("abort_quiet", 256'(nwr), 256'(0));

    load_pattern(1);
    run_pass(0);
    check_pass(1);

    check("rd_addr_range", 256'(oob), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
